// File: rtl/uart_rx_fifo.sv
// Purpose : UART receive buffer; syncs sampler flags, queues each byte once, counts framing errors.
// Latency : byte visible on rd_data/rd_valid 3 clk_sys edges after data_valid is first sampled high.
// Backpr. : rd_ready stalls the read port; a byte arriving while full with no pop is dropped (overflow).
//
// Ports
//   clk_sys, RST          system clock, synchronous active-high reset
//   data_rx, data_valid   sampler payload and its level-valid flag (baud domain)
//   frame_err, err_clr    sampler stop-bit error flag and its level clear handshake
//   rd_data/valid/ready   first-word fall-through read port
//   fifo_count            occupancy 0..DEPTH
//   overflow, ovf_clr     sticky drop flag and its clear
//   frame_err_cnt         saturating framing-error count
module uart_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk_sys,
    input  logic                     RST,
    input  logic [DATA_W-1:0]        data_rx,
    input  logic                     data_valid,
    input  logic                     frame_err,
    output logic                     err_clr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [ERR_CNT_W-1:0]     frame_err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    localparam logic [0:0] E_IDLE = 1'b0;
    localparam logic [0:0] E_CLR  = 1'b1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    // ------------------------------------------------------------------
    // Flag synchronizers: s1/s2 resolve metastability, s3 gives the
    // previous synchronized value for rising-edge detection.
    // ------------------------------------------------------------------
    logic dv_s1_q, dv_s2_q, dv_s3_q;
    logic fe_s1_q, fe_s2_q, fe_s3_q;

    always_ff @(posedge clk_sys) begin
        if (RST) begin
            dv_s1_q <= 1'b0;
            dv_s2_q <= 1'b0;
            dv_s3_q <= 1'b0;
            fe_s1_q <= 1'b0;
            fe_s2_q <= 1'b0;
            fe_s3_q <= 1'b0;
        end else begin
            dv_s1_q <= data_valid;
            dv_s2_q <= dv_s1_q;
            dv_s3_q <= dv_s2_q;
            fe_s1_q <= frame_err;
            fe_s2_q <= fe_s1_q;
            fe_s3_q <= fe_s2_q;
        end
    end

    logic dv_rise;
    logic fe_rise;

    // One pulse per high window, however long the sampler holds the flag.
    assign dv_rise = dv_s2_q & ~dv_s3_q;
    assign fe_rise = fe_s2_q & ~fe_s3_q;

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;
    logic head_is_new;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign pop        = rd_valid_q & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = dv_rise & (~fifo_full | pop);
    assign drop       = dv_rise & fifo_full & ~pop;

    // The incoming byte becomes the head when nothing else remains after
    // this cycle's pop; it is not in mem_q yet, so forward it directly.
    assign head_is_new = push & (fifo_empty | ((count_q == ONE_CNT) & pop));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as ovf_clr must not be lost.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Registered head: rd_valid mirrors next occupancy, rd_data holds its
    // last value whenever the FIFO goes empty.
    always_comb begin
        rd_valid_d = (count_d != '0);
        rd_data_d  = rd_data_q;
        if (count_d != '0) begin
            if (head_is_new) begin
                rd_data_d = data_rx;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage is left unreset; reset empties the FIFO by clearing the
    // pointers and count, so stale contents are never presented.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_rx;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Framing-error counter (saturating) and Err_clr handshake FSM
    // ------------------------------------------------------------------
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [0:0]           state_q, state_d;
    logic                 err_clr_q, err_clr_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (fe_rise && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // err_clr stays high until the sampler has visibly dropped frame_err,
    // which guarantees the slower baud domain has seen the clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            E_IDLE: begin
                if (fe_rise) begin
                    state_d = E_CLR;
                end
            end
            E_CLR: begin
                if (!fe_s2_q) begin
                    state_d = E_IDLE;
                end
            end
            default: state_d = E_IDLE;
        endcase
        err_clr_d = (state_d == E_CLR);
    end

    always_ff @(posedge clk_sys) begin
        if (RST) begin
            err_cnt_q <= '0;
            state_q   <= E_IDLE;
            err_clr_q <= 1'b0;
        end else begin
            err_cnt_q <= err_cnt_d;
            state_q   <= state_d;
            err_clr_q <= err_clr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign err_clr       = err_clr_q;
    assign frame_err_cnt = err_cnt_q;

endmodule
